// File: rtl/data_mem_responder.sv
// Data-memory responder: word-addressed array with in-order, fixed-latency
// read responses through a credit-limited response FIFO.

package Types;
   typedef struct packed {
      logic [31:0] r_addr;
      logic [31:0] w_addr;
      logic [31:0] w_data;
      logic        w_en;
   } memory_request;

   typedef struct packed {
      logic [31:0] r_data;
   } memory_response;
endpackage

module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS    = 256,
   parameter int unsigned LATENCY        = 2,
   parameter int unsigned RSP_FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  Types::memory_request req,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output Types::memory_response rsp
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = $clog2(RSP_FIFO_DEPTH + 1);
   localparam int unsigned IW = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
   localparam int unsigned FS = 1 << IW;
   localparam int unsigned PS = (LATENCY > 1) ? LATENCY - 1 : 1;

   localparam logic [CW-1:0] OUTST_MAX = CW'(RSP_FIFO_DEPTH);
   localparam logic [IW:0]   FIFO_MAX  = (IW + 1)'(RSP_FIFO_DEPTH);

   logic          accept;
   logic          pop;
   logic [AW-1:0] r_idx;
   logic [AW-1:0] w_idx;
   logic [31:0]   rd_word;
   logic          addr_unused;

   logic [31:0]   mem [DEPTH_WORDS];

   logic [CW-1:0] outst;

   logic [PS-1:0] pipe_valid;
   logic [31:0]   pipe_data [PS];

   logic          fifo_wr;
   logic [31:0]   fifo_wdata;
   logic [31:0]   fifo_mem [FS];
   logic [IW:0]   wr_ptr;
   logic [IW:0]   rd_ptr;
   logic [IW:0]   fifo_cnt;
   logic          fifo_empty;
   logic          fifo_full;

   // Handshake

   assign req_ready = !reset && (outst < OUTST_MAX);
   assign accept    = req_valid && req_ready;
   assign rsp_valid = !reset && !fifo_empty;
   assign pop       = rsp_valid && rsp_ready;

   // Low two bits select a byte within the word and upper bits wrap, so only
   // the word-index slice of each address reaches the array.
   assign r_idx       = req.r_addr[AW+1:2];
   assign w_idx       = req.w_addr[AW+1:2];
   assign addr_unused = ^{req.r_addr, req.w_addr};

   // Data array

   // Combinational read happens before the write at the accept edge, so a
   // request that reads and writes the same word returns the old contents.
   assign rd_word = mem[r_idx];

   always_ff @(posedge clk) begin
      if (accept && req.w_en) begin
         mem[w_idx] <= req.w_data;
      end
   end

   // Outstanding credit counter

   always_ff @(posedge clk) begin
      if (reset) begin
         outst <= '0;
      end else begin
         case ({accept, pop})
            2'b10:   outst <= outst + 1'b1;
            2'b01:   outst <= outst - 1'b1;
            default: outst <= outst;
         endcase
      end
   end

   // Latency pipeline

   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_valid <= '0;
      end else begin
         pipe_valid[0] <= accept;
         for (int unsigned i = 1; i < PS; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      pipe_data[0] <= rd_word;
      for (int unsigned i = 1; i < PS; i++) begin
         pipe_data[i] <= pipe_data[i-1];
      end
   end

   // The FIFO write itself is the last latency stage, so LATENCY-1 registers
   // precede it; with LATENCY=1 the read word goes straight into the FIFO.
   always_comb begin
      fifo_wr    = accept;
      fifo_wdata = rd_word;
      if (LATENCY > 1) begin
         fifo_wr    = pipe_valid[PS-1];
         fifo_wdata = pipe_data[PS-1];
      end
   end

   // Response FIFO

   assign fifo_cnt   = wr_ptr - rd_ptr;
   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == FIFO_MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (fifo_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         fifo_mem[wr_ptr[IW-1:0]] <= fifo_wdata;
      end
   end

   always_comb begin
      rsp = '0;
      if (rsp_valid) begin
         rsp.r_data = fifo_mem[rd_ptr[IW-1:0]];
      end
   end

   // Credit accounting must keep the FIFO from ever being written while full.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(fifo_wr && fifo_full));
         assert (outst <= OUTST_MAX);
         assert (!(pop && fifo_empty));
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder at default parameters.

module tb_data_mem_responder;
   import Types::*;

   logic           clk = 1'b0;
   logic           reset;
   logic           req_valid;
   logic           req_ready;
   memory_request  req;
   logic           rsp_valid;
   logic           rsp_ready;
   memory_response rsp;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_mem_responder #(
      .DEPTH_WORDS(256),
      .LATENCY(2),
      .RSP_FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req(req),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp(rsp)
   );

   // Called and returns on a falling edge; the request is accepted at the
   // rising edge in between.
   task automatic issue_one(input logic [31:0] ra, input logic [31:0] wa,
                            input logic [31:0] wd, input logic we);
      int n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL issue_ready: req_ready=%b, expected 1 within 20 cycles", req_ready);
      end
      req_valid = 1'b1;
      req = '{r_addr: ra, w_addr: wa, w_data: wd, w_en: we};
      @(negedge clk);
      req_valid = 1'b0;
      req.w_en  = 1'b0;
   endtask

   task automatic drain();
      rsp_ready = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (req_ready !== 1'b0) begin
         errors++; $display("FAIL reset_req_ready: got %b, expected 0", req_ready);
      end
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL reset_rsp_valid: got %b, expected 0", rsp_valid);
      end
      checks++;
      if (rsp.r_data !== 32'h0) begin
         errors++; $display("FAIL reset_rsp_data: got %h, expected 0", rsp.r_data);
      end
      checks++;
      if (dut.outst !== 3'd0) begin
         errors++; $display("FAIL reset_outst: got %0d, expected 0", dut.outst);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL post_reset_ready: got %b, expected 1", req_ready);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL idle_rsp_valid: got %b, expected 0", rsp_valid);
      end
   endtask

   task automatic test_latency();
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req = '{r_addr: 32'h0, w_addr: 32'h10, w_data: 32'hDEADBEEF, w_en: 1'b1};
      @(negedge clk);
      req = '{r_addr: 32'h10, w_addr: 32'h0, w_data: 32'h0, w_en: 1'b0};
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++; $display("FAIL raw_first_rsp_valid: got %b, expected 1", rsp_valid);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp.r_data !== 32'hDEADBEEF) begin
         errors++; $display("FAIL raw_read: valid=%b data=%h, expected 1/deadbeef", rsp_valid, rsp.r_data);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || rsp.r_data !== 32'h0) begin
         errors++; $display("FAIL raw_idle: valid=%b data=%h, expected 0/00000000", rsp_valid, rsp.r_data);
      end
      issue_one(32'h10, 32'h0, 32'h0, 1'b0);
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL lat_early: rsp_valid=%b one cycle after accept, expected 0", rsp_valid);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp.r_data !== 32'hDEADBEEF) begin
         errors++; $display("FAIL lat_exact: valid=%b data=%h, expected 1/deadbeef", rsp_valid, rsp.r_data);
      end
      drain();
   endtask

   task automatic test_read_before_write();
      issue_one(32'h0, 32'h20, 32'h11111111, 1'b1);
      drain();
      issue_one(32'h20, 32'h20, 32'h22222222, 1'b1);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp.r_data !== 32'h11111111) begin
         errors++; $display("FAIL rbw_old: valid=%b data=%h, expected 1/11111111", rsp_valid, rsp.r_data);
      end
      @(negedge clk);
      issue_one(32'h20, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp.r_data !== 32'h22222222) begin
         errors++; $display("FAIL rbw_new: valid=%b data=%h, expected 1/22222222", rsp_valid, rsp.r_data);
      end
      drain();
   endtask

   task automatic test_addr_map();
      issue_one(32'h0, 32'h403, 32'hA5A5A5A5, 1'b1);
      drain();
      issue_one(32'h0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp.r_data !== 32'hA5A5A5A5) begin
         errors++; $display("FAIL addr_wrap0: valid=%b data=%h, expected 1/a5a5a5a5", rsp_valid, rsp.r_data);
      end
      drain();
      issue_one(32'h0, 32'hFFFFFC05, 32'h5A5A0001, 1'b1);
      drain();
      issue_one(32'h6, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp.r_data !== 32'h5A5A0001) begin
         errors++; $display("FAIL addr_wrap1: valid=%b data=%h, expected 1/5a5a0001", rsp_valid, rsp.r_data);
      end
      drain();
   endtask

   task automatic test_backpressure();
      int idx = 0;
      int acc = 0;
      int got = 0;
      int first_pop = -10;
      logic acc_now;
      logic pop_now;
      logic [31:0] pop_data;
      for (int i = 0; i < 8; i++) begin
         issue_one(32'h0, 32'(i * 4), 32'(i), 1'b1);
      end
      drain();
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req = '{r_addr: 32'h0, w_addr: 32'h0, w_data: 32'h0, w_en: 1'b0};
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         if (cyc == 5) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp.r_data !== 32'h0 || req_ready !== 1'b0) begin
               errors++;
               $display("FAIL bp_hold_early: valid=%b data=%h ready=%b, expected 1/00000000/0",
                        rsp_valid, rsp.r_data, req_ready);
            end
         end
         if (cyc == 8) begin
            checks++;
            if (acc != 4) begin
               errors++; $display("FAIL bp_accepts: got %0d accepts, expected 4", acc);
            end
            checks++;
            if (rsp_valid !== 1'b1 || rsp.r_data !== 32'h0 || req_ready !== 1'b0) begin
               errors++;
               $display("FAIL bp_hold: valid=%b data=%h ready=%b, expected 1/00000000/0",
                        rsp_valid, rsp.r_data, req_ready);
            end
            rsp_ready = 1'b1;
         end
         if (cyc == first_pop + 1) begin
            checks++;
            if (req_ready !== 1'b1) begin
               errors++; $display("FAIL bp_credit_return: req_ready=%b after first pop, expected 1", req_ready);
            end
         end
         acc_now  = req_valid && req_ready;
         pop_now  = rsp_valid && rsp_ready;
         pop_data = rsp.r_data;
         if (pop_now) begin
            checks++;
            if (pop_data !== 32'(got)) begin
               errors++; $display("FAIL bp_order: response %0d data=%h, expected %h", got, pop_data, 32'(got));
            end
            if (got == 0) begin
               first_pop = cyc;
               checks++;
               if (req_ready !== 1'b0) begin
                  errors++; $display("FAIL bp_no_bypass: req_ready=%b in pop cycle, expected 0", req_ready);
               end
            end
            got++;
         end
         @(posedge clk);
         #1;
         if (acc_now) begin
            acc++;
            idx++;
            if (idx == 8) req_valid = 1'b0;
            else req.r_addr = 32'(idx * 4);
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      checks++;
      if (got != 8 || acc != 8) begin
         errors++; $display("FAIL bp_total: responses=%0d accepts=%0d, expected 8/8", got, acc);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      issue_one(32'h0, 32'h30, 32'hCAFEF00D, 1'b1);
      drain();
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req = '{r_addr: 32'h30, w_addr: 32'h0, w_data: 32'h0, w_en: 1'b0};
      repeat (2) @(negedge clk);
      req = '{r_addr: 32'h30, w_addr: 32'h34, w_data: 32'h12345678, w_en: 1'b1};
      @(negedge clk);
      req_valid = 1'b0;
      req.w_en  = 1'b0;
      checks++;
      if (dut.outst !== 3'd3) begin
         errors++; $display("FAIL mid_outst_before: got %0d, expected 3", dut.outst);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (dut.outst !== 3'd0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL mid_outst_after: outst=%0d ready=%b, expected 0/1", dut.outst, req_ready);
      end
      rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL mid_dropped: %0d stale rsp_valid cycles, expected 0", seen);
      end
      issue_one(32'h34, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp.r_data !== 32'h12345678) begin
         errors++; $display("FAIL mid_write_kept: valid=%b data=%h, expected 1/12345678", rsp_valid, rsp.r_data);
      end
      @(negedge clk);
      issue_one(32'h30, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp.r_data !== 32'hCAFEF00D) begin
         errors++; $display("FAIL mid_old_kept: valid=%b data=%h, expected 1/cafef00d", rsp_valid, rsp.r_data);
      end
      drain();
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      req       = '0;
      test_reset();
      test_latency();
      test_read_before_write();
      test_addr_map();
      test_backpressure();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
